// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the main-memory arbiter: FSM states, owner codes and
// the address/data widths that main_memory is also built with.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef struct packed {
    logic owner;
    logic write;
  } txn_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational two-way winner select between the fetch and data ports.
// Ties go to the data port when DATA_PRIO is set, otherwise away from rr_last.
module rr_pick2
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_PRIO = 0
) (
  input  logic f_req,
  input  logic d_req,
  input  logic rr_last,
  output logic win_vld,
  output logic win_owner
);

  always_comb begin
    win_vld   = f_req | d_req;
    win_owner = OWN_FETCH;
    if (f_req && d_req) begin
      win_owner = (DATA_PRIO != 0) ? OWN_DATA : ~rr_last;
    end else if (d_req) begin
      win_owner = OWN_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port synchronous memory between the fetch and load/store ports.
// One transaction at a time: IDLE -> ISSUE -> (WAIT x READ_LATENCY) -> RESP.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = 1,
  parameter int DATA_PRIO    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  logic [1:0] state;
  txn_t       txn;
  logic       rr_last;
  logic [2:0] wait_cnt;
  logic       win_vld;
  logic       win_owner;

  rr_pick2 #(
    .DATA_PRIO(DATA_PRIO)
  ) u_pick (
    .f_req    (f_req),
    .d_req    (d_req),
    .rr_last  (rr_last),
    .win_vld  (win_vld),
    .win_owner(win_owner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      txn       <= '0;
      rr_last   <= OWN_DATA;
      wait_cnt  <= '0;
      f_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      f_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_data  <= '0;
    end else begin
      // Grants and responses are single-cycle pulses.
      f_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            txn.owner <= win_owner;
            txn.write <= win_owner & d_we;
            rr_last   <= win_owner;
            mem_addr  <= (win_owner == OWN_DATA) ? d_addr : f_addr;
            if (win_owner == OWN_DATA && d_we) begin
              mem_wdata <= d_wdata;
              mem_we    <= 1'b1;
            end else begin
              mem_re <= 1'b1;
            end
            f_gnt <= (win_owner == OWN_FETCH);
            d_gnt <= (win_owner == OWN_DATA);
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          if (txn.write) begin
            // A write is acknowledged without touching rsp_data.
            f_rvalid <= (txn.owner == OWN_FETCH);
            d_rvalid <= (txn.owner == OWN_DATA);
            state    <= ST_RESP;
          end else begin
            wait_cnt <= LAT;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            rsp_data <= mem_rdata;
            f_rvalid <= (txn.owner == OWN_FETCH);
            d_rvalid <= (txn.owner == OWN_DATA);
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter in three configurations (latency 1/3/7, both tie policies),
// each with its own memory and a transaction-level timing model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [15:0] init_word(input logic [15:0] a);
    if (a == 16'h0010) return 16'hBEEF;
    if (a == 16'hFFFF) return 16'h0001;
    return a * 16'd3 + 16'h1357;
  endfunction

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 5) == 0) return 16'hFFFF;
    return 16'($urandom_range(0, 7));
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cfg%0d t=%0t: got %0h expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int RL = (g == 0) ? 1 : (g == 1) ? 3 : 7;
    localparam int DP = (g == 1) ? 1 : 0;

    logic        rst     = 1'b0;
    logic        f_req   = 1'b0;
    logic [15:0] f_addr  = 16'h0;
    logic        d_req   = 1'b0;
    logic        d_we    = 1'b0;
    logic [15:0] d_addr  = 16'h0;
    logic [15:0] d_wdata = 16'h0;
    logic        f_gnt, f_rvalid, d_gnt, d_rvalid, mem_we, mem_re;
    logic [15:0] rsp_data, mem_addr, mem_wdata, mem_rdata;
    bit          done = 1'b0;

    mem_arbiter #(
      .ADDR_W(16), .DATA_W(16), .READ_LATENCY(RL), .DATA_PRIO(DP)
    ) dut (
      .clk(clk), .reset(rst),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rsp_data(rsp_data),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata)
    );

    // Memory: words never written read back as init_word; read data appears
    // exactly RL cycles after the command and is poisoned otherwise.
    logic [15:0] mem_dat [65536];
    bit          mem_wr  [65536];
    logic [15:0] pipe    [8];
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) pipe[i] <= 16'h0;
      end else begin
        if (mem_we) begin
          mem_dat[mem_addr] <= mem_wdata;
          mem_wr[mem_addr]  <= 1'b1;
        end
        pipe[0] <= mem_re ? (mem_wr[mem_addr] ? mem_dat[mem_addr] : init_word(mem_addr)) : 16'hDEAD;
        for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign mem_rdata = pipe[RL-1];

    // Transaction-level model: when free, a request seen in cycle c is granted
    // at c+1 and answered at c+2 (write) or c+2+RL (read); free again after that.
    int          mc = 0;
    bit          busy = 1'b0;
    int          t_gnt = 0;
    int          t_rv = 0;
    bit          m_own = 1'b0;
    bit          m_we = 1'b0;
    bit          last_own = 1'b1;
    logic [15:0] m_addr = 16'h0;
    logic [15:0] m_wdata = 16'h0;
    logic [15:0] m_rdata = 16'h0;
    logic [15:0] exp_rsp = 16'h0;
    logic [15:0] shadow [int];
    bit          fg_prev = 1'b0;
    bit          dg_prev = 1'b0;

    function automatic logic [15:0] peek(input logic [15:0] a);
      if (shadow.exists(int'(a))) return shadow[int'(a)];
      return init_word(a);
    endfunction

    task automatic model_cycle();
      bit cmd, rv, was_busy;
      if (rst) begin
        busy = 1'b0;
        last_own = 1'b1;
        exp_rsp = 16'h0;
        chk("reset_handshake", g, {f_gnt, d_gnt, f_rvalid, d_rvalid, mem_re, mem_we}, 32'd0);
        chk("reset_addr_wdata", g, {mem_addr, mem_wdata}, 32'd0);
        chk("reset_rsp_data", g, rsp_data, 32'd0);
      end else begin
        cmd = busy && (mc == t_gnt);
        rv  = busy && (mc == t_rv);
        if (rv && !m_we) exp_rsp = m_rdata;
        chk("handshake", g, {f_gnt, d_gnt, f_rvalid, d_rvalid, mem_re, mem_we},
            {cmd && !m_own, cmd && m_own, rv && !m_own, rv && m_own, cmd && !m_we, cmd && m_we});
        chk("rsp_data", g, rsp_data, exp_rsp);
        if (cmd) chk("mem_addr", g, mem_addr, m_addr);
        if (cmd && m_we) chk("mem_wdata", g, mem_wdata, m_wdata);
        was_busy = busy;
        if (rv) busy = 1'b0;
        if (!was_busy && (f_req || d_req)) begin
          if (f_req && d_req) m_own = (DP != 0) ? 1'b1 : !last_own;
          else m_own = d_req;
          last_own = m_own;
          busy = 1'b1;
          t_gnt = mc + 1;
          m_we = m_own && d_we;
          m_addr = m_own ? d_addr : f_addr;
          m_wdata = d_wdata;
          if (m_we) begin
            shadow[int'(d_addr)] = d_wdata;
            t_rv = mc + 2;
          end else begin
            m_rdata = peek(m_addr);
            t_rv = mc + 2 + RL;
          end
        end
      end
      mc++;
    endtask

    task automatic tick();
      @(negedge clk);
      model_cycle();
      fg_prev = f_gnt;
      dg_prev = d_gnt;
      @(posedge clk);
      #1;
    endtask

    task automatic wait_any_gnt(output bit got, output bit who);
      got = 1'b0;
      who = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (f_gnt || d_gnt) begin
          got = 1'b1;
          who = d_gnt;
          break;
        end
      end
    endtask

    initial begin
      bit got, who, seen;
      #1 rst = 1'b1;
      #1;
      chk("reset_outputs", g, {f_gnt, d_gnt, f_rvalid, d_rvalid, mem_re, mem_we}, 32'd0);
      chk("reset_regs", g, {mem_addr, rsp_data}, 32'd0);
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();

      // Single fetch read of a preloaded word.
      f_req = 1'b1; f_addr = 16'h0010;
      tick();
      chk("fetch_gnt_cmd", g, {f_gnt, d_gnt, mem_re, mem_we}, 32'b1010);
      chk("fetch_mem_addr", g, mem_addr, 32'h0010);
      tick();
      f_req = 1'b0;
      repeat (RL) tick();
      chk("fetch_rvalid", g, {f_rvalid, d_rvalid}, 32'b10);
      chk("fetch_rsp_data", g, rsp_data, 32'hBEEF);
      tick();

      // Data write, then read it back.
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h1234; d_wdata = 16'hA5A5;
      tick();
      chk("write_gnt_cmd", g, {f_gnt, d_gnt, mem_re, mem_we}, 32'b0101);
      chk("write_addr_data", g, {mem_addr, mem_wdata}, 32'h1234A5A5);
      tick();
      d_req = 1'b0;
      chk("write_ack", g, {d_rvalid, f_rvalid, mem_we}, 32'b100);
      tick();
      d_req = 1'b1; d_we = 1'b0;
      tick();
      tick();
      d_req = 1'b0;
      repeat (RL) tick();
      chk("readback_rvalid", g, {f_rvalid, d_rvalid}, 32'b01);
      chk("readback_data", g, rsp_data, 32'hA5A5);
      tick();

      // Both ports held: alternate F,D,F,D or always D under data priority.
      f_req = 1'b1; f_addr = 16'h0005;
      d_req = 1'b1; d_addr = 16'h0006; d_we = 1'b0;
      for (int k = 0; k < 4; k++) begin
        wait_any_gnt(got, who);
        chk("tie_grant_order", g, {got, who}, {1'b1, (DP != 0) ? 1'b1 : 1'(k % 2)});
      end
      tick();
      d_req = 1'b0;
      wait_any_gnt(got, who);
      chk("fetch_after_data_drops", g, {got, who}, 32'b10);
      tick();
      f_req = 1'b0;
      repeat (RL + 4) tick();

      // Top-of-range address.
      f_req = 1'b1; f_addr = 16'hFFFF;
      tick();
      tick();
      f_req = 1'b0;
      repeat (RL) tick();
      chk("top_addr_rvalid", g, {f_rvalid, d_rvalid}, 32'b10);
      chk("top_addr_data", g, rsp_data, 32'h0001);
      tick();

      // Reset while waiting on read data.
      f_req = 1'b1; f_addr = 16'h0003;
      tick();
      tick();
      f_req = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("midwait_reset_handshake", g, {f_gnt, d_gnt, f_rvalid, d_rvalid, mem_re, mem_we}, 32'd0);
      chk("midwait_reset_addr_wdata", g, {mem_addr, mem_wdata}, 32'd0);
      chk("midwait_reset_rsp_data", g, rsp_data, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      seen = 1'b0;
      repeat (RL + 4) begin
        tick();
        seen |= f_rvalid | d_rvalid;
      end
      chk("no_rvalid_after_reset", g, seen, 32'd0);
      f_req = 1'b1; f_addr = 16'h0001;
      d_req = 1'b1; d_addr = 16'h0002; d_we = 1'b0;
      tick();
      chk("post_reset_tie", g, {f_gnt, d_gnt}, (DP != 0) ? 32'b01 : 32'b10);
      tick();
      f_req = 1'b0;
      d_req = 1'b0;
      repeat (RL + 3) tick();

      // Random traffic: each port requests at will and drops req after its grant.
      for (int k = 0; k < 1500; k++) begin
        tick();
        if (fg_prev) f_req = 1'b0;
        if (dg_prev) d_req = 1'b0;
        if (!f_req && $urandom_range(0, 2) == 0) begin
          f_req = 1'b1;
          f_addr = rand_addr();
        end
        if (!d_req && $urandom_range(0, 2) == 0) begin
          d_req = 1'b1;
          d_we = 1'($urandom_range(0, 1));
          d_addr = rand_addr();
          d_wdata = 16'($urandom);
        end
      end
      f_req = 1'b0;
      d_req = 1'b0;
      repeat (RL + 5) tick();
      done = 1'b1;
    end
  end

  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int c = 0; c < 60000 && !all_done; c++) begin
      @(posedge clk);
      all_done = cfg[0].done && cfg[1].done && cfg[2].done;
    end
    if (!all_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_timeout: got unfinished expected all configurations done");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
